// File: rtl/mips_seq_function_unit.sv
// Registered, multi-cycle MIPS function unit.
// One operation at a time is accepted when in_valid & in_ready. Single-cycle
// ops report one cycle after accept; the unsigned multiply (op 20) runs an
// iterative shift-add and reports WIDTH+1 cycles after accept.
// Optional: define MIPS_FU_DIV_EN to add op 21, an iterative unsigned
// restoring divide with the same latency as the multiply.
module mips_seq_function_unit #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       func_sel,
   input  logic [SHW-1:0]   shift,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   input  logic             c_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] func_out,
   output logic             z,
   output logic             n,
   output logic             c_out,
   output logic             v,
   output logic             n_xor_v_or_z
);

   localparam int MSB = WIDTH - 1;
   localparam int CNT_W = SHW + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

`ifdef MIPS_FU_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE, S_DIV} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

   state_t state, next_state;

   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] mcand, acc, mul_sum;
   logic [WIDTH-1:0]   mplier;

   logic [WIDTH:0]     add_sum, sub_sum, shl_word, shr_word;
   logic [WIDTH-1:0]   alu_res, res_d;
   logic               alu_c, alu_v, c_d, v_d;
   logic               load_res, load_mul;

`ifdef MIPS_FU_DIV_EN
   logic [WIDTH-1:0]   divisor, rem, quo;
   logic [WIDTH:0]     div_shift, div_trial;
   logic               div_ok, load_div;

   // Restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor when that does not go negative.
   assign div_shift = {rem, quo[MSB]};
   assign div_trial = div_shift - {1'b0, divisor};
   assign div_ok    = ~div_trial[WIDTH];
`endif

   // Adder/shifter words carry one extra bit so the carry-out falls out directly.
   assign add_sum  = {1'b0, in_A} + {1'b0, in_B}
                   + {{WIDTH{1'b0}}, (func_sel == 5'd3) & c_in};
   assign sub_sum  = {1'b0, in_A} + {1'b0, ~in_B} + {{WIDTH{1'b0}}, 1'b1};
   assign shl_word = {1'b0, in_A} << shift;
   assign shr_word = {in_A, 1'b0} >> shift;
   assign mul_sum  = mplier[0] ? acc + mcand : acc;

   assign in_ready     = (state == S_IDLE);
   assign out_valid    = (state == S_DONE);
   assign n_xor_v_or_z = (n ^ v) | z;

   // Single-cycle operation result and carry/overflow.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      alu_res = in_A;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (func_sel)
         5'd2, 5'd3: begin
            alu_res = add_sum[MSB:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (in_A[MSB] == in_B[MSB]) && (add_sum[MSB] != in_A[MSB]);
         end
         5'd5: begin
            alu_res = sub_sum[MSB:0];
            alu_c   = sub_sum[WIDTH];
            alu_v   = (in_A[MSB] != in_B[MSB]) && (sub_sum[MSB] != in_A[MSB]);
         end
         5'd8:    alu_res = in_A & in_B;
         5'd10:   alu_res = in_A | in_B;
         5'd12:   alu_res = in_A ^ in_B;
         5'd14:   alu_res = ~in_A;
         5'd16: begin
            alu_res = shl_word[MSB:0];
            alu_c   = shl_word[WIDTH];
         end
         5'd17: begin
            alu_res = shr_word[WIDTH:1];
            alu_c   = shr_word[0];
         end
         5'd18:   {alu_c, alu_res} = {in_A, c_in};
         5'd19:   {alu_res, alu_c} = {c_in, in_A};
         5'd31:   alu_res = add_sum[MSB:0];
         default: ;
      endcase
   end

   // Next-state logic and selection of the value registered into func_out/flags.
   always_comb begin
      next_state = state;
      load_res   = 1'b0;
      load_mul   = 1'b0;
      res_d      = alu_res;
      c_d        = alu_c;
      v_d        = alu_v;
`ifdef MIPS_FU_DIV_EN
      load_div   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               if (func_sel == 5'd20) begin
                  next_state = S_MUL;
                  load_mul   = 1'b1;
               end
`ifdef MIPS_FU_DIV_EN
               else if (func_sel == 5'd21) begin
                  next_state = S_DIV;
                  load_div   = 1'b1;
               end
`endif
               else begin
                  next_state = S_DONE;
                  load_res   = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (cnt == CNT_W'(1)) begin
               next_state = S_DONE;
               load_res   = 1'b1;
               res_d      = mul_sum[MSB:0];
               c_d        = |mul_sum[2*WIDTH-1:WIDTH];
               v_d        = c_d;
            end
         end
`ifdef MIPS_FU_DIV_EN
         S_DIV: begin
            if (cnt == CNT_W'(1)) begin
               next_state = S_DONE;
               load_res   = 1'b1;
               c_d        = 1'b0;
               v_d        = (divisor == '0);
               res_d      = v_d ? '1 : {quo[MSB-1:0], div_ok};
            end
         end
`endif
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Result/flag registers and iterative multiply (and divide) datapath.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the iteration registers are cleared too, so an aborted operation leaves no stale state.
      if (!reset_n) begin
         func_out <= '0;
         z        <= 1'b1;
         n        <= 1'b0;
         c_out    <= 1'b0;
         v        <= 1'b0;
         cnt      <= '0;
         mcand    <= '0;
         acc      <= '0;
         mplier   <= '0;
`ifdef MIPS_FU_DIV_EN
         divisor  <= '0;
         rem      <= '0;
         quo      <= '0;
`endif
      end else begin
         if (load_res) begin
            func_out <= res_d;
            z        <= (res_d == '0);
            n        <= res_d[MSB];
            c_out    <= c_d;
            v        <= v_d;
         end
         if (load_mul) begin
            mcand  <= {{WIDTH{1'b0}}, in_A};
            mplier <= in_B;
            acc    <= '0;
            cnt    <= CNT_INIT;
         end else if (state == S_MUL) begin
            acc    <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
         end
`ifdef MIPS_FU_DIV_EN
         if (load_div) begin
            divisor <= in_B;
            quo     <= in_A;
            rem     <= '0;
            cnt     <= CNT_INIT;
         end else if (state == S_DIV) begin
            rem     <= div_ok ? div_trial[MSB:0] : div_shift[MSB:0];
            quo     <= {quo[MSB-1:0], div_ok};
            cnt     <= cnt - CNT_W'(1);
         end
`endif
      end
   end

endmodule

// File: doc/mips_seq_function_unit.md
Name: mips_seq_function_unit

Overview:
- Parametrised, registered successor to the combinational MIPS function unit. Adds a WIDTH generic, a valid/ready issue handshake, registered results and flags, and an iterative multi-cycle unsigned multiply.
- Sits between the register-file read stage and write-back in the multi-cycle MIPS datapath. The control FSM issues one operation at a time and waits for out_valid.

Parameters:
WIDTH, 32, datapath width in bits; must be ≥4 and a power of two.
SHW, $clog2(WIDTH), width of the shift-amount port; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit idle; request accepted when in_valid & in_ready
func_sel  in  5  operation code, sampled on accept
shift  in  SHW  shift amount, sampled on accept
in_A  in  WIDTH  operand A, sampled on accept
in_B  in  WIDTH  operand B, sampled on accept
c_in  in  1  carry/rotate input, sampled on accept
out_valid  out  1  one-cycle pulse: result and flags updated
func_out  out  WIDTH  registered result
z  out  1  registered func_out==0
n  out  1  registered func_out[WIDTH-1]
c_out  out  1  registered carry
v  out  1  registered overflow
n_xor_v_or_z  out  1  (n^v)|z, combinational from the flag registers

Behaviour:
- Reset (async, reset_n=0):
  - FSM=IDLE, in_ready=1, out_valid=0.
  - func_out=0, z=1, n=0, c_out=0, v=0.
  - Internal multiply registers are cleared.
- Reset asserted mid-multiply aborts the operation; no out_valid is produced.
- FSM states: IDLE, MUL, DONE.
- IDLE, accept of a single-cycle op: compute and register result and flags at that edge, go to DONE. out_valid=1 in the cycle after accept (latency 1).
- IDLE, accept of op 20: load the multiplicand/multiplier registers, counter=WIDTH, go to MUL. in_ready=0 from the next cycle.
- MUL: one shift-add step per cycle, counter decrements.
  - When counter reaches 1, register the result and flags and go to DONE.
  - out_valid is high exactly WIDTH+1 cycles after accept.
- DONE: out_valid=1 for one cycle, in_ready=0, then return to IDLE.
- in_ready is high only in IDLE, so the maximum issue rate is one op per 2 cycles.
- In all states other than DONE, func_out and the flags hold their last values.
- All arithmetic is modulo 2^WIDTH. Any flag not listed for an op is registered as 0.
- Unless stated otherwise, n=msb(result) and z=(result==0) for every op.
- Operation codes:
  - 0, 7: pass A.
  - 2: A+B; c_out=carry out of bit WIDTH-1; v=signed overflow.
  - 3: A+B+c_in; same c_out/v rules as op 2.
  - 5: A-B computed as A+~B+1; c_out=carry out (1 means no borrow); v=signed overflow, including the case B=most-negative.
  - 8: A&B.
  - 10: A|B.
  - 12: A^B.
  - 14: ~A.
  - 16: A<<shift; c_out=last bit shifted out, 0 when shift=0.
  - 17: logical A>>shift; c_out=last bit shifted out, 0 when shift=0.
  - 18: {A[WIDTH-2:0],c_in}; c_out=A[WIDTH-1].
  - 19: {c_in,A[WIDTH-1:1]}; c_out=A[0].
  - 20: unsigned A*B, low WIDTH bits; c_out=v=(high WIDTH bits ≠0).
  - 31: A+B with c_out=v=0 (address add).
  - Any other code: pass A.
- in_valid while in_ready=0 is ignored; no queueing.

Optional Feature:
- Macro MIPS_FU_DIV_EN.
- Defined: adds op 21, an unsigned restoring divide using state DIV.
  - One quotient bit per cycle; out_valid WIDTH+1 cycles after accept.
  - func_out=quotient; remainder is discarded.
  - B=0: func_out=all ones, v=1, c_out=0, with the same latency.
- Undefined: op 21 behaves as pass A (latency 1), and no DIV state or divider registers exist.

Test Plan:
- Reset during the MUL state (reset_n low at cycle 5 after accepting 20, A=3, B=5) -> immediately in_ready=1, func_out=0, z=1; no out_valid pulse.
- WIDTH=32, op 2, A=0x7FFFFFFF, B=1 -> out_valid in the next cycle; func_out=0x80000000, v=1, c_out=0, n=1, n_xor_v_or_z=0.
- Op 5, A=0, B=0x80000000 -> func_out=0x80000000, v=1, c_out=0. Op 5, A=5, B=5 -> z=1, c_out=1.
- Op 20, A=0x10000, B=0x10000 -> out_valid exactly 33 cycles after accept; func_out=0, c_out=v=1, z=1. A second in_valid during MUL is ignored.
- WIDTH=8, op 17, A=0x81, shift=1 -> func_out=0x40, c_out=1. Op 16, shift=0 -> func_out=A, c_out=0.
- With MIPS_FU_DIV_EN defined: op 21, A=100, B=7 -> func_out=14 after WIDTH+1 cycles. Op 21 with B=0 -> func_out=all ones, v=1.
